// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register.
//
// It captures the register-file read data and the decoded fields from the
// decode stage on every rising clock edge. It detects load-use hazards against
// the instruction currently in execute. On a load-use hazard or on a
// branch/jump flush it inserts a bubble, and it counts the bubbles it inserts.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   *D inputs             decode-stage instruction (valid, data, indices, control)
//   FlushE                execute redirect; kill the instruction entering EX
//   *E outputs            registered execute-stage copies of the D inputs
//   StallF, StallD        hold PC and IF/ID (combinational, equal to lwStall)
//   BubbleCount           bubbles inserted since reset (wraps)
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             ValidD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic             FlushE,

  output logic             ValidE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,

  output logic             StallF,
  output logic             StallD,
  output logic [CNT_W-1:0] BubbleCount
);

  localparam logic [1:0] RES_MEM = 2'b01;

  logic lw_stall;
  logic bubble;

  // A valid load in EX whose destination (not x0) matches either source in D.
  // Both sources are compared even when the D instruction does not read them.
  // This can stall when no stall is needed, which is acceptable.
  always_comb begin
    lw_stall = ValidE & RegWriteE & (ResultSrcE == RES_MEM) & (RdE != 5'd0) &
               ValidD & ((RdE == Rs1D) | (RdE == Rs2D));
    bubble   = FlushE | lw_stall;
  end

  assign StallF = lw_stall;
  assign StallD = lw_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ValidE      <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
    end else if (bubble) begin
      // Bubble: a NOP enters EX. Data and index fields are cleared as well.
      // Forwarding therefore never matches a stale index.
      ValidE      <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
    end else begin
      // An empty decode slot is still captured. Its control bits are gated off.
      // This stops a stale decode from writing state downstream.
      ValidE      <= ValidD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
      ImmExtE     <= ImmExtD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      RegWriteE   <= RegWriteD & ValidD;
      MemWriteE   <= MemWriteD & ValidD;
      JumpE       <= JumpD & ValidD;
      BranchE     <= BranchD & ValidD;
      ALUSrcE     <= ALUSrcD & ValidD;
      ResultSrcE  <= ValidD ? ResultSrcD : 2'b00;
      ALUControlE <= ALUControlD;
    end
  end

  // One count per bubble cycle. A flush and a stall in the same cycle count once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       BubbleCount <= '0;
    else if (bubble) BubbleCount <= BubbleCount + 1'b1;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, FlushE;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, StallF, StallD;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE;
  logic [CNT_W-1:0] BubbleCount;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .RD1D(RD1D), .RD2D(RD2D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ImmExtD(ImmExtD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .FlushE(FlushE), .ValidE(ValidE), .RD1E(RD1E),
    .RD2E(RD2E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .StallF(StallF), .StallD(StallD),
    .BubbleCount(BubbleCount)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Set up a decode instruction. Data fields are derived from rd, so each slot is distinct.
  task automatic set_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic [1:0] rsrc);
    ValidD = v; Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; ResultSrcD = rsrc;
    RD1D = 32'h100 + rd; RD2D = 32'h200 + rd; ImmExtD = 32'h4; PCD = 32'h1000 + rd;
    PCPlus4D = 32'h1004 + rd; MemWriteD = 1'b0; JumpD = 1'b0; BranchD = 1'b0;
    ALUSrcD = 1'b0; ALUControlD = 3'b000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; FlushE = 1'b0;
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
    #12;
    chk("rst_valid", ValidE, 0);
    chk("rst_rd1", RD1E, 0);
    chk("rst_cnt", BubbleCount, 0);
    chk("rst_stall", StallF, 0);
    @(negedge clk); reset = 1'b0;

    // Pass-through
    set_d(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 2'b00);
    RD1D = 32'h11; RD2D = 32'h22; ImmExtD = 32'hFFFF_FFF0; ALUControlD = 3'b010;
    MemWriteD = 1'b1; BranchD = 1'b1; ALUSrcD = 1'b1;
    chk("pt_before", ValidE, 0);
    tick();
    chk("pt_valid", ValidE, 1);
    chk("pt_rd1", RD1E, 32'h11);
    chk("pt_rd2", RD2E, 32'h22);
    chk("pt_imm", ImmExtE, 32'hFFFF_FFF0);
    chk("pt_rd", RdE, 5);
    chk("pt_rs1", Rs1E, 1);
    chk("pt_rs2", Rs2E, 2);
    chk("pt_pc", PCE, 32'h1005);
    chk("pt_pc4", PCPlus4E, 32'h1009);
    chk("pt_rw", RegWriteE, 1);
    chk("pt_mw", MemWriteE, 1);
    chk("pt_br", BranchE, 1);
    chk("pt_jmp", JumpE, 0);
    chk("pt_alusrc", ALUSrcE, 1);
    chk("pt_aluc", ALUControlE, 3'b010);
    chk("pt_cnt", BubbleCount, 0);

    // Load-use: lw x5, then add x6 that reads x5 through rs2
    @(negedge clk); set_d(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 2'b01);
    tick();
    chk("lw_res", ResultSrcE, 2'b01);
    chk("lw_stall_prev", StallF, 0);
    @(negedge clk); set_d(1'b1, 5'd3, 5'd5, 5'd6, 1'b1, 2'b00);
    #1;
    chk("lu_stallf", StallF, 1);
    chk("lu_stalld", StallD, 1);
    tick();
    chk("lu_bub_valid", ValidE, 0);
    chk("lu_bub_rw", RegWriteE, 0);
    chk("lu_bub_res", ResultSrcE, 0);
    chk("lu_bub_rd", RdE, 0);
    chk("lu_cnt", BubbleCount, 1);
    chk("lu_stall_off", StallF, 0);
    tick();
    chk("lu_cap_valid", ValidE, 1);
    chk("lu_cap_rd", RdE, 6);
    chk("lu_cap_rs2", Rs2E, 5);
    chk("lu_cap_rd1", RD1E, 32'h106);
    chk("lu_cap_cnt", BubbleCount, 1);

    // A load to x0 never stalls
    @(negedge clk); set_d(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 2'b01);
    tick();
    @(negedge clk); set_d(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 2'b00);
    #1;
    chk("x0_nostall", StallF, 0);
    tick();
    chk("x0_cap_valid", ValidE, 1);
    chk("x0_cap_rd", RdE, 7);
    chk("x0_cnt", BubbleCount, 1);

    // Flush and load-use in the same cycle count as one bubble
    @(negedge clk); set_d(1'b1, 5'd1, 5'd1, 5'd8, 1'b1, 2'b01);
    tick();
    @(negedge clk); set_d(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 2'b00); FlushE = 1'b1;
    #1;
    chk("fs_stall", StallD, 1);
    tick();
    chk("fs_valid", ValidE, 0);
    chk("fs_cnt", BubbleCount, 2);
    @(negedge clk); FlushE = 1'b0;
    tick();
    chk("fs_cap_rd", RdE, 9);
    chk("fs_cnt2", BubbleCount, 2);

    // An empty decode slot is captured as invalid with its control bits gated off. It is not a bubble.
    @(negedge clk); set_d(1'b0, 5'd1, 5'd2, 5'd10, 1'b1, 2'b10); MemWriteD = 1'b1; JumpD = 1'b1;
    tick();
    chk("inv_valid", ValidE, 0);
    chk("inv_rw", RegWriteE, 0);
    chk("inv_mw", MemWriteE, 0);
    chk("inv_jmp", JumpE, 0);
    chk("inv_res", ResultSrcE, 0);
    chk("inv_cnt", BubbleCount, 2);

    // Reset asserted mid-cycle while a stall is pending
    @(negedge clk); set_d(1'b1, 5'd1, 5'd0, 5'd11, 1'b1, 2'b01);
    tick();
    @(negedge clk); set_d(1'b1, 5'd11, 5'd0, 5'd12, 1'b1, 2'b00);
    #1;
    chk("mr_pre_stall", StallF, 1);
    chk("mr_pre_valid", ValidE, 1);
    reset = 1'b1;
    #1;
    chk("mr_valid", ValidE, 0);
    chk("mr_rw", RegWriteE, 0);
    chk("mr_rd", RdE, 0);
    chk("mr_pc", PCE, 0);
    chk("mr_res", ResultSrcE, 0);
    chk("mr_cnt", BubbleCount, 0);
    chk("mr_stallf", StallF, 0);
    chk("mr_stalld", StallD, 0);

    // Counter wrap with a 4-bit counter
    @(negedge clk); reset = 1'b0; FlushE = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("wrap_15", BubbleCount, 15);
    tick(); tick();
    chk("wrap_17", BubbleCount, 1);
    chk("wrap_valid", ValidE, 0);
    @(negedge clk); FlushE = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
